memory: RTL and testbench
=========================

Name: memory

Overview:
- Single-port, synchronous, word-addressed RAM with a valid/ready request handshake.
- One transaction per clock: a read or a write selected by read_write_en.
- Generic on-chip storage block, sized by parameters. Testbenches may load or dump the storage array directly.

Parameters:
- DEPTH, 1024, number of words stored.
- WIDTH, 32, bits per word.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_write_en  input  1  1 = write, 0 = read; sampled only when valid=1.
- valid  input  1  request strobe, sampled on rising clk.
- write  input  WIDTH  write data.
- address  input  ADDR_WIDTH  word address.
- ready  output  1  registered completion flag for the request sampled on the previous edge.
- read  output  WIDTH  registered read data.

Behaviour:
- Storage is an internal array named memory, declared [WIDTH-1:0] memory [0:DEPTH-1].
  - The name and shape are fixed so hierarchical $readmemh/$writememh on <inst>.memory works.
- Reset (rst=1, asynchronous, immediate):
  - ready=0, read=0.
  - Array clearing is controlled by the Optional Feature.
  - While rst is high, all requests are ignored.
- Each rising clk with rst=0 and valid=1:
  - read_write_en=1: memory[address] <= write; read holds its previous value.
  - read_write_en=0: read <= memory[address].
  - ready <= 1.
- Each rising clk with rst=0 and valid=0: ready <= 0; read holds; memory unchanged.
- Latency: request sampled at edge N; ready=1 and read data valid after edge N, until edge N+1.
- Back-to-back operation:
  - valid may stay high for consecutive cycles; every edge with valid=1 is a new transaction.
  - Throughput is one word per clock; ready remains 1 throughout.
- No stall: ready never deasserts while valid is held; the requester never waits more than one cycle.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Address >= DEPTH (only possible when DEPTH is not a power of two):
  - Writes are dropped.
  - Reads return 0.
  - ready still asserts.
- Reset asserted mid-transaction: the in-flight ready/read are cleared immediately; no partial write occurs.
- Outputs are not tri-stated; read is never X after reset.

Optional Feature:
- Macro: MEM_CLEAR_ON_RST_EN.
- Defined: reset also zeroes every array word. The array holds all zeros from reset assertion until the first write.
- Undefined: the array is not touched by reset. Contents persist across reset, and power-up contents are undefined until written or loaded by the testbench.
- Port behaviour is otherwise identical in both builds.

Test Plan:
- Front-door write then read: write addresses 0..1023 with distinct random data (valid held, read_write_en=1), then read 0..1023 (read_write_en=0). Every read equals the written word; ready=1 for each of the 2048 transactions.
- Back-door load, front-door read: $readmemh a file of data_i = i*3 into dut.memory, then read 0..1023. read = i*3 one cycle after each request.
- Front-door write, back-door dump: write addresses 0..1023 with data_i = ~i, then $writememh dut.memory. The dump file matches ~i per line. With MEM_CLEAR_ON_RST_EN, a dump taken right after reset is all zeros.
- Handshake timing: single read of address 5 holding 0xDEADBEEF. ready=0 before the edge, 1 for exactly one cycle after it, then 0 once valid drops; read=0xDEADBEEF and holds after ready falls.
- Read-after-write: write 0x12345678 to address 7, then read address 7 on the very next cycle. read=0x12345678.
- Async reset: assert rst between clock edges while ready=1 and read=0xA5A5A5A5. ready and read go to 0 immediately without a clock edge. With MEM_CLEAR_ON_RST_EN undefined, a subsequent read of the same address returns the prior contents.

Source files
------------

// File: rtl/memory.sv
// Single-port word-addressed RAM with a one-cycle valid/ready handshake.
// Define MEM_CLEAR_ON_RST_EN to have reset also zero the storage array.
module memory #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_write_en,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      write,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  ready,
    output logic [WIDTH-1:0]      read
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [WIDTH-1:0] memory [0:DEPTH-1];

    logic             ready_q;
    logic             ready_d;
    logic [WIDTH-1:0] read_q;
    logic [WIDTH-1:0] read_d;
    logic             in_range;
    logic             mem_we;

    always_comb begin
        in_range = (32'(address) < DEPTH_U);
        mem_we   = valid && read_write_en && in_range && !rst;
    end

    // Out-of-range reads return zero; the array is never indexed past DEPTH.
    always_comb begin
        ready_d = 1'b0;
        read_d  = read_q;
        if (valid) begin
            ready_d = 1'b1;
            if (!read_write_en) begin
                read_d = in_range ? memory[address] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            read_q  <= '0;
        end else begin
            ready_q <= ready_d;
            read_q  <= read_d;
        end
    end

`ifdef MEM_CLEAR_ON_RST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                memory[i] <= '0;
            end
        end else if (mem_we) begin
            memory[address] <= write;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            memory[address] <= write;
        end
    end
`endif

    assign ready = ready_q;
    assign read  = read_q;

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for memory: full-array write/read,
// back-door inspection, handshake timing, read-after-write, async reset.
module tb_memory;

    logic        clk;
    logic        rst;
    logic        read_write_en;
    logic        valid;
    logic [31:0] write;
    logic [9:0]  address;
    logic        ready;
    logic [31:0] read;

    logic        rw2;
    logic        v2;
    logic [7:0]  w2;
    logic [2:0]  a2;
    logic        ready2;
    logic [7:0]  read2;

    logic [31:0] exp_mem [1024];
    logic [31:0] exp_after_rst;
    int          passed;
    int          total;

    memory dut (
        .clk          (clk),
        .rst          (rst),
        .read_write_en(read_write_en),
        .valid        (valid),
        .write        (write),
        .address      (address),
        .ready        (ready),
        .read         (read)
    );

    // Non-power-of-two depth exercises the out-of-range address path.
    memory #(.DEPTH(6), .WIDTH(8)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .read_write_en(rw2),
        .valid        (v2),
        .write        (w2),
        .address      (a2),
        .ready        (ready2),
        .read         (read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic rw,
                        input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        valid         = v;
        read_write_en = rw;
        address       = a;
        write         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic rw, input logic [2:0] a,
                         input logic [7:0] d);
        @(negedge clk);
        v2  = 1'b1;
        rw2 = rw;
        a2  = a;
        w2  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst           = 1'b1;
        valid         = 1'b0;
        read_write_en = 1'b0;
        address       = '0;
        write         = '0;
        v2            = 1'b0;
        rw2           = 1'b0;
        a2            = '0;
        w2            = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_read", read, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            exp_mem[i] = $urandom;
        end
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 1'b1, 10'(i), exp_mem[i]);
            check("wr_ready", {31'b0, ready}, 32'd1);
            check("wr_read_hold", read, 32'd0);
        end
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 1'b0, 10'(i), 32'd0);
            check("rd_ready", {31'b0, ready}, 32'd1);
            check("rd_data", read, exp_mem[i]);
        end

        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 1'b1, 10'(i), ~32'(i));
            check("wr2_ready", {31'b0, ready}, 32'd1);
        end
        for (int i = 0; i < 1024; i++) begin
            check("backdoor", dut.memory[i], ~32'(i));
        end

        step(1'b0, 1'b0, 10'd0, 32'd0);
        check("idle_ready", {31'b0, ready}, 32'd0);
        check("idle_read_hold", read, exp_mem[1023]);

        step(1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
        step(1'b0, 1'b0, 10'd0, 32'd0);
        @(negedge clk);
        valid         = 1'b1;
        read_write_en = 1'b0;
        address       = 10'd5;
        #1;
        check("hs_pre_edge", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1;
        check("hs_ready", {31'b0, ready}, 32'd1);
        check("hs_read", read, 32'hDEADBEEF);
        step(1'b0, 1'b0, 10'd0, 32'd0);
        check("hs_ready_fall", {31'b0, ready}, 32'd0);
        check("hs_read_hold", read, 32'hDEADBEEF);

        step(1'b1, 1'b1, 10'd7, 32'h12345678);
        step(1'b1, 1'b0, 10'd7, 32'd0);
        check("raw_read", read, 32'h12345678);

        step(1'b1, 1'b1, 10'd9, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 10'd9, 32'd0);
        check("ar_pre_ready", {31'b0, ready}, 32'd1);
        check("ar_pre_read", read, 32'hA5A5A5A5);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ready_async", {31'b0, ready}, 32'd0);
        check("ar_read_async", read, 32'd0);
        @(negedge clk);
        read_write_en = 1'b1;
        write         = 32'h0BADF00D;
        address       = 10'd9;
        @(posedge clk);
        #1;
        check("ar_ready_held", {31'b0, ready}, 32'd0);
`ifdef MEM_CLEAR_ON_RST_EN
        check("ar_cleared", dut.memory[5], 32'd0);
        exp_after_rst = 32'd0;
`else
        exp_after_rst = 32'hA5A5A5A5;
`endif
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        step(1'b1, 1'b0, 10'd9, 32'd0);
        check("ar_ready_after", {31'b0, ready}, 32'd1);
        check("ar_persist", read, exp_after_rst);
        step(1'b0, 1'b0, 10'd0, 32'd0);

        step2(1'b1, 3'd6, 8'h77);
        check("oor_wr_ready", {31'b0, ready2}, 32'd1);
        step2(1'b1, 3'd5, 8'h3C);
        step2(1'b0, 3'd5, 8'h00);
        check("d2_rd5", {24'b0, read2}, 32'h3C);
        step2(1'b0, 3'd6, 8'h00);
        check("oor_rd_ready", {31'b0, ready2}, 32'd1);
        check("oor_rd_zero", {24'b0, read2}, 32'd0);
        @(negedge clk);
        v2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
